// File: rtl/aib_avmm_cfg_master_if.sv
// Command, response and AVMM configuration bus signals for aib_avmm_cfg_master.
// The master modport is the initiator's view; slave is the sequencer/bus-model side.
interface aib_avmm_cfg_master_if #(
  parameter int ADDR_WIDTH = 17
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [3:0]            cmd_byte_en;
  logic [31:0]           cmd_wdata;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic                  rsp_is_read;
  logic [31:0]           rsp_rdata;
  logic                  rsp_err;

  logic [ADDR_WIDTH-1:0] o_cfg_avmm_addr;
  logic [3:0]            o_cfg_avmm_byte_en;
  logic                  o_cfg_avmm_read;
  logic                  o_cfg_avmm_write;
  logic [31:0]           o_cfg_avmm_wdata;
  logic                  i_cfg_avmm_waitreq;
  logic                  i_cfg_avmm_rdatavld;
  logic [31:0]           i_cfg_avmm_rdata;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_byte_en, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_is_read, rsp_rdata, rsp_err,
    input  rsp_ready,
    output o_cfg_avmm_addr, o_cfg_avmm_byte_en, o_cfg_avmm_read,
    output o_cfg_avmm_write, o_cfg_avmm_wdata,
    input  i_cfg_avmm_waitreq, i_cfg_avmm_rdatavld, i_cfg_avmm_rdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_byte_en, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_is_read, rsp_rdata, rsp_err,
    output rsp_ready,
    input  o_cfg_avmm_addr, o_cfg_avmm_byte_en, o_cfg_avmm_read,
    input  o_cfg_avmm_write, o_cfg_avmm_wdata,
    output i_cfg_avmm_waitreq, i_cfg_avmm_rdatavld, i_cfg_avmm_rdata
  );
endinterface

// File: rtl/aib_avmm_cfg_master.sv
// AVMM configuration initiator: one command in, one AVMM transfer out, one response back,
// with a per-phase timeout that forces an error response if the channel bus hangs.
module aib_avmm_cfg_master #(
  parameter int ADDR_WIDTH     = 17,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TO_CNT_WIDTH   = 8
) (
  input logic                    i_cfg_avmm_clk,
  input logic                    i_cfg_avmm_rst_n,
  aib_avmm_cfg_master_if.master  bus
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] REQ     = 2'd1;
  localparam logic [1:0] WAIT_RD = 2'd2;
  localparam logic [1:0] RSP     = 2'd3;

  localparam bit                      TO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TO_CNT_WIDTH-1:0] TO_LAST = TO_CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]              state;
  logic [TO_CNT_WIDTH-1:0] to_cnt;
  logic                    to_hit;

  assign bus.cmd_ready = (state == IDLE);
  assign to_hit        = TO_EN && (to_cnt == TO_LAST);

  always_ff @(posedge i_cfg_avmm_clk or negedge i_cfg_avmm_rst_n) begin
    if (!i_cfg_avmm_rst_n) begin
      state                  <= IDLE;
      to_cnt                 <= '0;
      bus.o_cfg_avmm_addr    <= '0;
      bus.o_cfg_avmm_byte_en <= '0;
      bus.o_cfg_avmm_wdata   <= '0;
      bus.o_cfg_avmm_read    <= 1'b0;
      bus.o_cfg_avmm_write   <= 1'b0;
      bus.rsp_valid          <= 1'b0;
      bus.rsp_is_read        <= 1'b0;
      bus.rsp_rdata          <= '0;
      bus.rsp_err            <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.o_cfg_avmm_addr    <= bus.cmd_addr;
            bus.o_cfg_avmm_byte_en <= bus.cmd_byte_en;
            bus.o_cfg_avmm_wdata   <= bus.cmd_wdata;
            bus.o_cfg_avmm_read    <= !bus.cmd_write;
            bus.o_cfg_avmm_write   <= bus.cmd_write;
            to_cnt                 <= '0;
            state                  <= REQ;
          end
        end

        REQ: begin
          if (!bus.i_cfg_avmm_waitreq) begin
            bus.o_cfg_avmm_read  <= 1'b0;
            bus.o_cfg_avmm_write <= 1'b0;
            if (bus.o_cfg_avmm_write) begin
              bus.rsp_valid   <= 1'b1;
              bus.rsp_err     <= 1'b0;
              bus.rsp_rdata   <= '0;
              bus.rsp_is_read <= 1'b0;
              state           <= RSP;
            end else if (bus.i_cfg_avmm_rdatavld) begin
              // Slave may return data on the same edge the request is accepted
              bus.rsp_valid   <= 1'b1;
              bus.rsp_err     <= 1'b0;
              bus.rsp_rdata   <= bus.i_cfg_avmm_rdata;
              bus.rsp_is_read <= 1'b1;
              state           <= RSP;
            end else begin
              to_cnt <= '0;
              state  <= WAIT_RD;
            end
          end else if (to_hit) begin
            bus.o_cfg_avmm_read  <= 1'b0;
            bus.o_cfg_avmm_write <= 1'b0;
            bus.rsp_valid        <= 1'b1;
            bus.rsp_err          <= 1'b1;
            bus.rsp_rdata        <= '0;
            bus.rsp_is_read      <= bus.o_cfg_avmm_read;
            state                <= RSP;
          end else begin
            to_cnt <= to_cnt + TO_CNT_WIDTH'(1);
          end
        end

        WAIT_RD: begin
          if (bus.i_cfg_avmm_rdatavld) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rdata   <= bus.i_cfg_avmm_rdata;
            bus.rsp_is_read <= 1'b1;
            state           <= RSP;
          end else if (to_hit) begin
            bus.rsp_valid   <= 1'b1;
            bus.rsp_err     <= 1'b1;
            bus.rsp_rdata   <= '0;
            bus.rsp_is_read <= 1'b1;
            state           <= RSP;
          end else begin
            to_cnt <= to_cnt + TO_CNT_WIDTH'(1);
          end
        end

        RSP: begin
          if (bus.rsp_ready) begin
            bus.rsp_valid <= 1'b0;
            state         <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aib_avmm_cfg_master.sv
// Directed bench for aib_avmm_cfg_master: stimulus pushes expected responses into a
// scoreboard queue, and a monitor pops and compares each response as it appears.
module tb_aib_avmm_cfg_master;

  localparam int AW = 17;

  typedef struct packed {
    logic        is_read;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  rsp_t exp_q[$];

  aib_avmm_cfg_master_if #(.ADDR_WIDTH(AW)) bus ();

  aib_avmm_cfg_master #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (8),
    .TO_CNT_WIDTH   (8)
  ) dut (
    .i_cfg_avmm_clk   (clk),
    .i_cfg_avmm_rst_n (rst_n),
    .bus              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check_output(input string name, input logic [31:0] act,
                                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic apply_stimulus(input logic wr, input logic [AW-1:0] addr,
                                input logic [3:0] be, input logic [31:0] wd);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 50) begin
      tick();
      n++;
    end
    check_output("cmd_ready_at_issue", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid   = 1'b1;
    bus.cmd_write   = wr;
    bus.cmd_addr    = addr;
    bus.cmd_byte_en = be;
    bus.cmd_wdata   = wd;
    tick();
    bus.cmd_valid   = 1'b0;
  endtask

  task automatic push_exp(input logic is_read, input logic [31:0] rdata, input logic err);
    rsp_t e;
    e.is_read = is_read;
    e.rdata   = rdata;
    e.err     = err;
    exp_q.push_back(e);
  endtask

  // Monitor: compares each newly presented response against the scoreboard head
  initial begin
    logic prev_valid;
    rsp_t e;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      check_output("strobe_exclusive",
                   32'(bus.o_cfg_avmm_read & bus.o_cfg_avmm_write), 32'd0);
      if (bus.rsp_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_response", 32'(bus.rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check_output("rsp_is_read", 32'(bus.rsp_is_read), 32'(e.is_read));
          check_output("rsp_rdata", bus.rsp_rdata, e.rdata);
          check_output("rsp_err", 32'(bus.rsp_err), 32'(e.err));
        end
      end
      prev_valid = bus.rsp_valid;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n                   = 1'b0;
    bus.cmd_valid           = 1'b0;
    bus.cmd_write           = 1'b0;
    bus.cmd_addr            = '0;
    bus.cmd_byte_en         = '0;
    bus.cmd_wdata           = '0;
    bus.rsp_ready           = 1'b1;
    bus.i_cfg_avmm_waitreq  = 1'b0;
    bus.i_cfg_avmm_rdatavld = 1'b0;
    bus.i_cfg_avmm_rdata    = '0;

    tick();
    tick();
    check_output("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check_output("reset_read", 32'(bus.o_cfg_avmm_read), 32'd0);
    check_output("reset_write", 32'(bus.o_cfg_avmm_write), 32'd0);
    check_output("reset_addr", 32'(bus.o_cfg_avmm_addr), 32'd0);
    check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check_output("reset_rsp_rdata", bus.rsp_rdata, 32'd0);
    rst_n = 1'b1;
    tick();

    // Zero-wait write
    push_exp(1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 17'h00208, 4'hF, 32'hA5A5_0001);
    check_output("t1_write_hi", 32'(bus.o_cfg_avmm_write), 32'd1);
    check_output("t1_read_lo", 32'(bus.o_cfg_avmm_read), 32'd0);
    check_output("t1_addr", 32'(bus.o_cfg_avmm_addr), 32'h00208);
    check_output("t1_be", 32'(bus.o_cfg_avmm_byte_en), 32'hF);
    check_output("t1_wdata", bus.o_cfg_avmm_wdata, 32'hA5A5_0001);
    check_output("t1_rsp_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    check_output("t1_write_drop", 32'(bus.o_cfg_avmm_write), 32'd0);
    check_output("t1_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();
    check_output("t1_rsp_taken", 32'(bus.rsp_valid), 32'd0);
    check_output("t1_idle", 32'(bus.cmd_ready), 32'd1);

    // Read stalled 5 cycles, data 3 cycles after acceptance
    bus.i_cfg_avmm_waitreq = 1'b1;
    push_exp(1'b1, 32'h1234_5678, 1'b0);
    apply_stimulus(1'b0, 17'h00400, 4'hF, 32'h0);
    for (int i = 0; i < 6; i++) begin
      check_output("t2_read_held", 32'(bus.o_cfg_avmm_read), 32'd1);
      check_output("t2_addr_stable", 32'(bus.o_cfg_avmm_addr), 32'h00400);
      if (i == 5) bus.i_cfg_avmm_waitreq = 1'b0;
      tick();
    end
    check_output("t2_read_drop", 32'(bus.o_cfg_avmm_read), 32'd0);
    check_output("t2_rsp_early", 32'(bus.rsp_valid), 32'd0);
    tick();
    tick();
    bus.i_cfg_avmm_rdatavld = 1'b1;
    bus.i_cfg_avmm_rdata    = 32'h1234_5678;
    tick();
    bus.i_cfg_avmm_rdatavld = 1'b0;
    bus.i_cfg_avmm_rdata    = 32'h0;
    check_output("t2_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();

    // Read with waitreq stuck: timeout in the request phase
    bus.i_cfg_avmm_waitreq = 1'b1;
    push_exp(1'b1, 32'h0, 1'b1);
    apply_stimulus(1'b0, 17'h00500, 4'hF, 32'h0);
    for (int i = 0; i < 8; i++) begin
      check_output("t3_read_held", 32'(bus.o_cfg_avmm_read), 32'd1);
      tick();
    end
    check_output("t3_read_drop", 32'(bus.o_cfg_avmm_read), 32'd0);
    check_output("t3_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    bus.i_cfg_avmm_waitreq = 1'b0;
    tick();
    push_exp(1'b0, 32'h0, 1'b0);
    apply_stimulus(1'b1, 17'h1FFFF, 4'h3, 32'hDEAD_BEEF);
    check_output("t3_next_write", 32'(bus.o_cfg_avmm_write), 32'd1);
    check_output("t3_next_addr", 32'(bus.o_cfg_avmm_addr), 32'h1FFFF);
    check_output("t3_next_be", 32'(bus.o_cfg_avmm_byte_en), 32'h3);
    tick();
    check_output("t3_next_rsp", 32'(bus.rsp_valid), 32'd1);
    tick();

    // Read accepted, data never returns: timeout in WAIT_RD
    push_exp(1'b1, 32'h0, 1'b1);
    apply_stimulus(1'b0, 17'h00600, 4'hF, 32'h0);
    check_output("t4_read_hi", 32'(bus.o_cfg_avmm_read), 32'd1);
    tick();
    check_output("t4_read_drop", 32'(bus.o_cfg_avmm_read), 32'd0);
    for (int k = 0; k < 7; k++) begin
      tick();
      check_output("t4_no_rsp_yet", 32'(bus.rsp_valid), 32'd0);
    end
    tick();
    check_output("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    tick();

    // Same-edge read data, then a held response with stray rdatavld
    bus.rsp_ready = 1'b0;
    push_exp(1'b1, 32'hCAFE_0042, 1'b0);
    apply_stimulus(1'b0, 17'h00300, 4'hF, 32'h0);
    bus.i_cfg_avmm_rdatavld = 1'b1;
    bus.i_cfg_avmm_rdata    = 32'hCAFE_0042;
    tick();
    bus.i_cfg_avmm_rdata    = 32'hFFFF_FFFF;
    for (int i = 0; i < 10; i++) begin
      check_output("t5_rsp_held", 32'(bus.rsp_valid), 32'd1);
      check_output("t5_rdata_held", bus.rsp_rdata, 32'hCAFE_0042);
      check_output("t5_cmd_ready_lo", 32'(bus.cmd_ready), 32'd0);
      tick();
    end
    bus.i_cfg_avmm_rdatavld = 1'b0;
    bus.rsp_ready           = 1'b1;
    tick();
    check_output("t5_rsp_taken", 32'(bus.rsp_valid), 32'd0);
    check_output("t5_idle", 32'(bus.cmd_ready), 32'd1);
    bus.i_cfg_avmm_rdatavld = 1'b1;
    tick();
    tick();
    check_output("t5_idle_stray_rsp", 32'(bus.rsp_valid), 32'd0);
    check_output("t5_idle_stray_ready", 32'(bus.cmd_ready), 32'd1);
    bus.i_cfg_avmm_rdatavld = 1'b0;
    bus.i_cfg_avmm_rdata    = 32'h0;

    // Reset while a write is stalled: no response may follow
    bus.i_cfg_avmm_waitreq = 1'b1;
    apply_stimulus(1'b1, 17'h00100, 4'hF, 32'h5555_AAAA);
    check_output("t6_write_hi", 32'(bus.o_cfg_avmm_write), 32'd1);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check_output("t6_write_async", 32'(bus.o_cfg_avmm_write), 32'd0);
    check_output("t6_rsp_async", 32'(bus.rsp_valid), 32'd0);
    check_output("t6_addr_async", 32'(bus.o_cfg_avmm_addr), 32'd0);
    tick();
    rst_n = 1'b1;
    bus.i_cfg_avmm_waitreq = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_output("t6_cmd_ready", 32'(bus.cmd_ready), 32'd1);
      check_output("t6_no_rsp", 32'(bus.rsp_valid), 32'd0);
    end

    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
